// File: rtl/alu_ctrl_muldiv_if.sv
// Handshake bundle between decode and the ALU control / mul-div block.
interface alu_ctrl_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       opcode;
    logic [5:0]       func_field;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, opcode, func_field, operand_a, operand_b,
        input  in_ready, out_valid, alu_control, result, hi, lo, busy
    );

    modport slave (
        input  in_valid, opcode, func_field, operand_a, operand_b,
        output in_ready, out_valid, alu_control, result, hi, lo, busy
    );
endinterface

// File: rtl/alu_ctrl_muldiv.sv
// Registered ALU control decoder with iterative mul/div engine and HI/LO.
module alu_ctrl_muldiv #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              rst_n,
    alu_ctrl_muldiv_if.slave bus
);
    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0] p_q, p_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   a_q, a_d;
    logic           bneg_q, bneg_d;
    logic           sgn_q, sgn_d;
    logic           div_q, div_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           ov_q, ov_d;
    logic [2:0]     alu_q, alu_d;
    logic [W-1:0]   res_q, res_d;

    logic           is_r, is_md, in_sgn;
    logic [2:0]     dec;
    logic [W:0]     sum, r_ext, diff;
    logic [2*W-1:0] mul_nx, div_nx, prod;
    logic [W-1:0]   q_fix, r_fix;

    always_comb begin
        is_r  = bus.opcode == 6'h00;
        is_md = is_r && (bus.func_field[5:2] == 4'b0110);
        in_sgn = !bus.func_field[0];
        dec = 3'd0;
        unique case (1'b1)
            is_r: begin
                case (bus.func_field)
                    6'h22:   dec = 3'd1;
                    6'h24:   dec = 3'd2;
                    6'h25:   dec = 3'd3;
                    6'h27:   dec = 3'd4;
                    6'h2A:   dec = 3'd5;
                    default: dec = 3'd0;
                endcase
            end
            bus.opcode == 6'h04: dec = 3'd1;
            bus.opcode == 6'h0C: dec = 3'd2;
            bus.opcode == 6'h0D: dec = 3'd3;
            bus.opcode == 6'h0A: dec = 3'd5;
            default:             dec = 3'd0;
        endcase
    end

    // Multiply step: conditional add into the upper half, then shift right.
    // Divide step: shift left, trial-subtract, restore on borrow.
    always_comb begin
        sum    = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_nx = {sum, p_q[W-1:1]};
        r_ext  = {p_q[2*W-1:W], p_q[W-1]};
        diff   = r_ext - {1'b0, m_q};
        div_nx = diff[W] ? {r_ext[W-1:0], p_q[W-2:0], 1'b0}
                         : {diff[W-1:0], p_q[W-2:0], 1'b1};
        prod   = (sgn_q && (a_q[W-1] ^ bneg_q)) ? -p_q : p_q;
        q_fix  = (sgn_q && (a_q[W-1] ^ bneg_q)) ? -p_q[W-1:0] : p_q[W-1:0];
        r_fix  = (sgn_q && a_q[W-1]) ? -p_q[2*W-1:W] : p_q[2*W-1:W];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        a_d     = a_q;
        bneg_d  = bneg_q;
        sgn_d   = sgn_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ov_d    = 1'b0;
        alu_d   = 3'd0;
        res_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && is_md) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    div_d   = bus.func_field[1];
                    sgn_d   = in_sgn;
                    a_d     = bus.operand_a;
                    bneg_d  = in_sgn && bus.operand_b[W-1];
                    p_d     = {{W{1'b0}},
                               (in_sgn && bus.operand_a[W-1]) ?
                               -bus.operand_a : bus.operand_a};
                    m_d     = (in_sgn && bus.operand_b[W-1]) ?
                              -bus.operand_b : bus.operand_b;
                end else if (bus.in_valid) begin
                    ov_d  = 1'b1;
                    alu_d = dec;
                    if (is_r && bus.func_field == 6'h10) res_d = hi_q;
                    if (is_r && bus.func_field == 6'h12) res_d = lo_q;
                end
            end
            RUN: begin
                p_d   = div_q ? div_nx : mul_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == W'(W - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                cnt_d   = '0;
                ov_d    = 1'b1;
                if (!div_q) begin
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
                end else if (m_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end
                res_d = lo_d;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            a_q     <= '0;
            bneg_q  <= 1'b0;
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ov_q    <= 1'b0;
            alu_q   <= 3'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            a_q     <= a_d;
            bneg_q  <= bneg_d;
            sgn_q   <= sgn_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ov_q    <= ov_d;
            alu_q   <= alu_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready    = state_q == IDLE;
    assign bus.busy        = state_q != IDLE;
    assign bus.out_valid   = ov_q;
    assign bus.alu_control = alu_q;
    assign bus.result      = res_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed vectors and multi-cycle sequences for alu_ctrl_muldiv, WIDTH=8.
module tb_alu_ctrl_muldiv;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    alu_ctrl_muldiv_if #(.WIDTH(8)) bus_i ();

    alu_ctrl_muldiv #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [2:0] alu;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op,
                         input logic [5:0] fn, input logic [7:0] a,
                         input logic [7:0] b);
        bus_i.in_valid   = v;
        bus_i.opcode     = op;
        bus_i.func_field = fn;
        bus_i.operand_a  = a;
        bus_i.operand_b  = b;
    endtask

    // Accept a mul/div op, scramble inputs, wait for completion, check.
    task automatic run_md(input string name, input logic [5:0] fn,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ehi, input logic [7:0] elo);
        int cyc;
        int early;
        drive(1'b1, 6'h00, fn, a, b);
        tick();
        drive(1'b0, 6'h00, 6'h20, 8'h5A, 8'hC3);
        cyc = 0;
        early = 0;
        while (!bus_i.in_ready && cyc < 20) begin
            if (bus_i.out_valid || !bus_i.busy) early++;
            cyc++;
            tick();
        end
        chk({name, "_busy_cycles"}, 16'(cyc), 16'd9);
        chk({name, "_early_out"}, 16'(early), 16'd0);
        chk({name, "_out_valid"}, {15'd0, bus_i.out_valid}, 16'd1);
        chk({name, "_hilo"}, {bus_i.hi, bus_i.lo}, {ehi, elo});
        chk({name, "_result"}, {5'd0, bus_i.alu_control, bus_i.result},
            {8'd0, elo});
    endtask

    initial begin
        int cyc;
        int bad;
        n_cmp = 0;
        n_err = 0;
        vecs[0]  = '{6'h00, 6'h22, 3'd1, 8'h00};
        vecs[1]  = '{6'h0C, 6'h00, 3'd2, 8'h00};
        vecs[2]  = '{6'h00, 6'h20, 3'd0, 8'h00};
        vecs[3]  = '{6'h00, 6'h24, 3'd2, 8'h00};
        vecs[4]  = '{6'h00, 6'h25, 3'd3, 8'h00};
        vecs[5]  = '{6'h00, 6'h27, 3'd4, 8'h00};
        vecs[6]  = '{6'h00, 6'h2A, 3'd5, 8'h00};
        vecs[7]  = '{6'h00, 6'h3F, 3'd0, 8'h00};
        vecs[8]  = '{6'h04, 6'h22, 3'd1, 8'h00};
        vecs[9]  = '{6'h23, 6'h00, 3'd0, 8'h00};
        vecs[10] = '{6'h2B, 6'h27, 3'd0, 8'h00};
        vecs[11] = '{6'h08, 6'h00, 3'd0, 8'h00};
        vecs[12] = '{6'h0D, 6'h00, 3'd3, 8'h00};
        vecs[13] = '{6'h0A, 6'h00, 3'd5, 8'h00};
        vecs[14] = '{6'h3F, 6'h24, 3'd0, 8'h00};
        vecs[15] = '{6'h00, 6'h10, 3'd0, 8'h00};
        vecs[16] = '{6'h00, 6'h12, 3'd0, 8'h00};

        rst_n = 1'b0;
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (2) tick();
        chk("rst_ready_busy", {14'd0, bus_i.in_ready, bus_i.busy}, 16'd2);
        chk("rst_out_valid", {15'd0, bus_i.out_valid}, 16'd0);
        chk("rst_alu_res", {5'd0, bus_i.alu_control, bus_i.result}, 16'd0);
        chk("rst_hilo", {bus_i.hi, bus_i.lo}, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].fn, 8'(i * 37), 8'(i * 11));
            tick();
            chk($sformatf("vec%0d_valid", i),
                {15'd0, bus_i.out_valid}, 16'd1);
            chk($sformatf("vec%0d_alu_res", i),
                {5'd0, bus_i.alu_control, bus_i.result},
                {5'd0, vecs[i].alu, vecs[i].res});
        end
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        tick();
        chk("idle_no_pulse", {15'd0, bus_i.out_valid}, 16'd0);

        run_md("mult", 6'h18, 8'hFD, 8'h05, 8'hFF, 8'hF1);
        drive(1'b1, 6'h00, 6'h10, 8'h00, 8'h00);
        tick();
        chk("mfhi_after_mult", {7'd0, bus_i.out_valid, bus_i.result},
            16'h01FF);
        drive(1'b1, 6'h00, 6'h12, 8'h00, 8'h00);
        tick();
        chk("mflo_after_mult", {7'd0, bus_i.out_valid, bus_i.result},
            16'h01F1);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);

        run_md("multu", 6'h19, 8'hFD, 8'h05, 8'h04, 8'hF1);
        run_md("mult_neg_neg", 6'h18, 8'h80, 8'h80, 8'h40, 8'h00);
        run_md("div", 6'h1A, 8'h07, 8'hFE, 8'h01, 8'hFD);
        run_md("divu", 6'h1B, 8'h07, 8'hFE, 8'h07, 8'h00);
        run_md("div_neg_rem", 6'h1A, 8'hF9, 8'h02, 8'hFF, 8'hFD);
        run_md("div_ovf", 6'h1A, 8'h80, 8'hFF, 8'h00, 8'h80);
        run_md("div_zero", 6'h1A, 8'h85, 8'h00, 8'h85, 8'hFF);
        run_md("divu_big", 6'h1B, 8'hC8, 8'h07, 8'h04, 8'h1C);

        // divu by zero with the next instruction held valid while busy
        drive(1'b1, 6'h00, 6'h1B, 8'h2A, 8'h00);
        tick();
        drive(1'b1, 6'h0D, 6'h00, 8'h11, 8'h22);
        cyc = 0;
        bad = 0;
        while (!bus_i.in_ready && cyc < 20) begin
            if (bus_i.out_valid) bad++;
            cyc++;
            tick();
        end
        chk("held_busy_cycles", 16'(cyc), 16'd9);
        chk("held_no_accept", 16'(bad), 16'd0);
        chk("divu0_hilo", {bus_i.hi, bus_i.lo}, 16'h2AFF);
        chk("divu0_out", {7'd0, bus_i.out_valid, bus_i.result}, 16'h01FF);
        tick();
        chk("held_accept", {12'd0, bus_i.out_valid, bus_i.alu_control},
            16'h000B);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        tick();

        // reset during the fourth RUN cycle of multu
        drive(1'b1, 6'h00, 6'h19, 8'h10, 8'h10);
        tick();
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        repeat (3) tick();
        chk("pre_rst_busy", {15'd0, bus_i.busy}, 16'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_busy", {14'd0, bus_i.in_ready, bus_i.busy},
            16'd2);
        chk("midrst_hilo", {bus_i.hi, bus_i.lo}, 16'd0);
        chk("midrst_outs", {4'd0, bus_i.out_valid, bus_i.alu_control,
            bus_i.result}, 16'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 8'h03, 8'h04);
        tick();
        chk("post_rst_add", {12'd0, bus_i.out_valid, bus_i.alu_control},
            16'h0008);
        drive(1'b1, 6'h00, 6'h22, 8'h03, 8'h04);
        tick();
        chk("post_rst_sub", {12'd0, bus_i.out_valid, bus_i.alu_control},
            16'h0009);
        drive(1'b0, 6'h00, 6'h00, 8'h00, 8'h00);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus_i.out_valid || bus_i.busy) bad++;
        end
        chk("no_stale_pulse", 16'(bad), 16'd0);
        chk("post_rst_hilo", {bus_i.hi, bus_i.lo}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout");
        $fatal(1, "watchdog");
    end
endmodule
